// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// with one chunk of carry resolved per cycle and a valid/ready handshake on both ends.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int C = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0 || WIDTH < STAGES) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and >= STAGES");
    end

    logic stall;
    logic ovf_reg;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             valid_reg;
        logic [WIDTH-1:0] a_reg;
        logic [WIDTH-1:0] b_reg;
        logic [WIDTH-1:0] sum_reg;
        logic             carry_reg;

        logic             src_valid;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic             src_carry;

        logic [C-1:0]     chunk_sum;
        logic             chunk_cout;
        logic             chunk_cmsb;
        logic [WIDTH-1:0] sum_next;

        // Stage 0 folds subtraction in: invert B and force the carry-in.
        if (gi == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_a     = a;
            assign src_b     = sub ? ~b : b;
            assign src_sum   = '0;
            assign src_carry = sub ? 1'b1 : cin;
        end else begin : g_next
            assign src_valid = g_stage[gi-1].valid_reg;
            assign src_a     = g_stage[gi-1].a_reg;
            assign src_b     = g_stage[gi-1].b_reg;
            assign src_sum   = g_stage[gi-1].sum_reg;
            assign src_carry = g_stage[gi-1].carry_reg;
        end

        // Bit-serial ripple over this stage's chunk; chunk_cmsb is the carry into its top bit.
        always_comb begin
            logic c;
            c          = src_carry;
            chunk_cmsb = src_carry;
            chunk_sum  = '0;
            for (int i = 0; i < C; i++) begin
                chunk_cmsb   = c;
                chunk_sum[i] = src_a[gi*C+i] ^ src_b[gi*C+i] ^ c;
                c            = (src_a[gi*C+i] & src_b[gi*C+i]) |
                               (src_a[gi*C+i] & c) |
                               (src_b[gi*C+i] & c);
            end
            chunk_cout = c;
        end

        always_comb begin
            sum_next            = src_sum;
            sum_next[gi*C +: C] = chunk_sum;
        end

        // Bubbles carry their (don't-care) data too, so a stall freezes every register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                a_reg     <= '0;
                b_reg     <= '0;
                sum_reg   <= '0;
                carry_reg <= 1'b0;
            end else if (!stall) begin
                valid_reg <= src_valid;
                a_reg     <= src_a;
                b_reg     <= src_b;
                sum_reg   <= sum_next;
                carry_reg <= chunk_cout;
            end
        end

        if (gi == STAGES - 1) begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg <= 1'b0;
                end else if (!stall) begin
                    ovf_reg <= chunk_cmsb ^ chunk_cout;
                end
            end
        end

        // Operand bits past their chunk, and the MSB carry of inner stages, are dead by design.
        logic unused_bits;
        assign unused_bits = ^{src_a, src_b, src_sum, a_reg, b_reg, chunk_cmsb};
    end

    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign sum       = g_stage[STAGES-1].sum_reg;
    assign cout      = g_stage[STAGES-1].carry_reg;
    assign ovf       = ovf_reg;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): directed vector table,
// back-to-back, backpressure, mid-stream reset and a random scoreboard run.
module tb_pipelined_adder;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              cin = 1'b0;
    logic              sub = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              ovf;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
        string       name;
    } vec_t;

    exp_t sb[$];
    int   pop_cnt   = 0;
    int   first_pop = 0;
    int   last_pop  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic msub);
        logic [15:0] bb;
        logic [16:0] full;
        exp_t        e;
        bb     = msub ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub ? 1'b1 : mcin)};
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (ma[15] == bb[15]) && (full[15] != ma[15]);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                                input logic vsub, input logic [15:0] vs, input logic vc,
                                input logic vo, input string vn);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub;
        v.exp_sum = vs; v.exp_cout = vc; v.exp_ovf = vo; v.name = vn;
        return v;
    endfunction

    // One clock of stimulus: drive, settle, score both handshakes, advance one edge.
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic isub, input logic ordy,
                        input bit chk_lat, output bit acc);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ordy;
        #1;
        acc = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got sum %h with out_valid=1, required no output", sum);
            end else begin
                e = sb.pop_front();
                check("result", 32'({sum, cout, ovf}), 32'({e.sum, e.cout, e.ovf}));
                if (chk_lat) check("latency", cyc - e.cyc, STAGES);
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
        end
        if (in_valid && in_ready) begin
            e     = model(ia, ib, icin, isub);
            e.cyc = cyc;
            sb.push_back(e);
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit chk_lat);
        bit acc;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, chk_lat, acc);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        bit acc;
        int lat;

        vecs[0] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_ripple");
        vecs[1] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        vecs[2] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        vecs[3] = mk(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "borrow_cin_ignored");
        vecs[4] = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_cin");
        vecs[5] = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_zero");
        vecs[6] = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "max_add_cin");
        vecs[7] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf_wrap");
        vecs[8] = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "chunk_boundary");
        vecs[9] = mk(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "cin_ripple_all");

        // Reset state while rst_n is held low.
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vector table: one op at a time, latency and result checked.
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            a         = vecs[i].a;
            b         = vecs[i].b;
            cin       = vecs[i].cin;
            sub       = vecs[i].sub;
            out_ready = 1'b1;
            #1;
            check($sformatf("%s_in_ready", vecs[i].name), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("%s_latency", vecs[i].name), lat, STAGES);
            check($sformatf("%s_sum", vecs[i].name), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("%s_cout", vecs[i].name), 32'(cout), 32'(vecs[i].exp_cout));
            check($sformatf("%s_ovf", vecs[i].name), 32'(ovf), 32'(vecs[i].exp_ovf));
            @(posedge clk);
            #1;
        end

        // Back-to-back: 8 ops, results on 8 consecutive cycles, each STAGES after accept.
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(16'h1111 * i + 16'h0F00), 16'(16'h2345 + 16'h0101 * i),
                 1'(i % 2), 1'(i / 4), 1'b1, 1'b1, acc);
            check("b2b_accept", 32'(acc), 32'd1);
        end
        drain(1'b1);
        check("b2b_count", pop_cnt, 8);
        check("b2b_consecutive", last_pop - first_pop, 7);

        // Backpressure: fill the pipe with out_ready low, then hold 3 stalled cycles.
        for (int i = 0; i < STAGES; i++) begin
            step(1'b1, 16'(16'hA000 + i), 16'(16'h0F0F * (i + 1)), 1'b1, 1'(i % 2), 1'b0, 1'b0, acc);
        end
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, acc);
            check("stall_no_accept", 32'(acc), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_frozen", 32'({sum, cout, ovf}), 32'({sb[0].sum, sb[0].cout, sb[0].ovf}));
        end
        // out_ready rises together with a new op: it must be accepted the same cycle.
        step(1'b1, 16'h1357, 16'h2468, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        check("release_accept", 32'(acc), 32'd1);
        drain(1'b0);
        check("backpressure_sb_size", 32'(sb.size()), 32'd0);

        // Mid-stream reset with a full, stalled pipe holding non-zero results.
        step(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < STAGES; i++) begin
            step(1'b1, 16'(16'h0101 * (i + 3)), 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        end
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_sum", 32'(sum), 32'd0);
        check("midreset_cout", 32'(cout), 32'd0);
        check("midreset_ovf", 32'(ovf), 32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        pop_cnt = 0;
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        drain(1'b1);
        check("post_reset_pops", pop_cnt, 1);

        // Random handshake traffic against the scoreboard.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'b0, acc);
        end
        drain(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
